sram_arb_ctrl_64x20: RTL
========================

# sram_arb_ctrl_64x20

Two-requester controller for the single-port 64x20 SRAM macro. It clears every word to zero after reset, then shares the macro between two requesters with round-robin arbitration and valid/ready handshakes, one access per cycle. Read data returns to the requesting port with a fixed latency. It sits directly between the macro's port 0 pins and the two client blocks.

## Interface
- DATA_WIDTH, 20, word width; equals macro DATA_WIDTH
- ADDR_WIDTH, 6, address width; depth = 1 << ADDR_WIDTH
- INIT_ENABLE, 1, 1 = zero-fill after reset; 0 = go straight to RUN

- clk0  in  1  clock, shared with macro clk0
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port request accepted this cycle
- req_we  in  2  per-port 1 = write, 0 = read
- req_addr  in  2*ADDR_WIDTH  per-port address; port i is in bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  2*DATA_WIDTH  per-port write data, packed the same way
- rsp_valid  out  2  per-port read data valid, one-cycle pulse
- rsp_rdata  out  DATA_WIDTH  read data, shared by both ports; qualified by rsp_valid
- init_done  out  1  high once zero-fill is complete
- csb0, web0, wmask0, addr0, din0  out  1/1/1/ADDR_WIDTH/DATA_WIDTH  macro controls
- dout0  in  DATA_WIDTH  macro read data

## Operation
- FSM states: INIT and RUN.
  - After reset: INIT if INIT_ENABLE=1, otherwise RUN.
  - INIT: init counter runs 0..63 and issues one write of zeros per cycle (csb0=0, web0=0, din0=0).
  - INIT -> RUN after the write to address 63 is issued. init_done rises in the same cycle.
  - req_ready is 0 throughout INIT.
- RUN arbitration:
  - req_ready[i] = RUN && req_valid[i] && (!req_valid[1-i] || rr_ptr==i).
  - When both ports are valid, rr_ptr toggles after each grant. With a single valid port, rr_ptr is unchanged.
  - rr_ptr resets to 0.
- Issue: on an accepted handshake, the granted request is registered onto the macro pins: csb0=0, web0=!we, addr0, din0.
  - wmask0 is tied to 1.
  - With no grant, csb0=1 and addr0/din0 hold their previous values.
- Read tracking: a 2-stage shift of {valid, port id} tracks each read. rsp_rdata is captured from dout0 when that entry reaches stage 2.
- No response backpressure. Clients must accept rsp_valid when it is asserted.
- Writes produce no response.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0 (1 if INIT_ENABLE=0), csb0=1, web0=1, wmask0=1, addr0=0, din0=0, rr_ptr=0, init counter=0.
- Read latency:
  - Handshake at edge E0 -> macro samples its pins at E1.
  - Macro reads at the negedge of the cycle that follows E1, before T_HOLD expires.
  - dout0 is registered at E2, so rsp_valid is high during the cycle after E2.
  - Total: 2 cycles from acceptance.
- Throughput: 1 access per cycle, back-to-back reads and writes in any mix.
- Write-then-read to the same address in consecutive cycles returns the new data. The macro writes at the negedge before the read.
- Zero-fill takes 64 cycles. First RUN handshake is possible in the cycle after init_done rises.
- Reset asserted mid-operation:
  - All pending responses are dropped and outputs return to reset values.
  - If INIT_ENABLE=1, zero-fill restarts at address 0.
- req_valid may drop without a handshake. The controller does not require the request to be held.

## Structure
- Package sram_arb_ctrl_pkg holds:
  - state enum {ST_INIT, ST_RUN}
  - DATA_WIDTH/ADDR_WIDTH defaults
  - latency constant RD_LAT=2
- Sub-module sram_rr_arb2: two-way round-robin grant. Inputs valid[1:0] and enable; outputs grant[1:0], plus the rr_ptr register.
- The top level holds the FSM, init counter, pin registers and the read-tracking shift.

## Test plan
- Reset release, INIT_ENABLE=1 -> 64 consecutive writes with din0=0 to addresses 0..63; init_done rises on the 64th; then a read of address 37 returns 0.
- Port 0 writes 0xABCDE to address 5, then reads address 5 in the next cycle -> rsp_valid[0] 2 cycles after the read handshake, rsp_rdata=0xABCDE.
- Both ports hold reads valid for 4 cycles -> grants alternate 0,1,0,1; rsp_valid alternates with matching data.
- Port 1 alone valid for 3 cycles -> req_ready[1] high all 3 cycles; rr_ptr unchanged.
- rst_n pulsed low one cycle after a read handshake -> no rsp_valid; csb0=1 immediately; zero-fill restarts at address 0.
- INIT_ENABLE=0 -> init_done=1 out of reset; a first request accepted in cycle 1 completes with the normal read latency.

Source files
------------

// File: rtl/sram_arb_ctrl_pkg.sv
// sram_arb_ctrl_pkg: shared types and constants for the 64x20 SRAM arbiter/controller
package sram_arb_ctrl_pkg;
    localparam int DATA_WIDTH = 20;
    localparam int ADDR_WIDTH = 6;
    localparam int RD_LAT     = 2;
    typedef enum logic {ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/sram_rr_arb2.sv
// sram_rr_arb2: two-way round-robin grant with a pointer that only moves under contention
module sram_rr_arb2 (
    input  logic       clk0,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output logic       rr_ptr
);
    assign grant[0] = enable && valid[0] && (!valid[1] || !rr_ptr);
    assign grant[1] = enable && valid[1] && (!valid[0] || rr_ptr);
    // pointer flips only when both ports competed for the grant
    always_ff @(posedge clk0 or negedge rst_n)
        if (!rst_n)
            rr_ptr <= 1'b0;
        else if (enable && &valid)
            rr_ptr <= !rr_ptr;
endmodule

// File: rtl/sram_arb_ctrl_64x20.sv
// sram_arb_ctrl_64x20: zero-fills the macro after reset, then arbitrates two requesters onto port 0
module sram_arb_ctrl_64x20
    import sram_arb_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = sram_arb_ctrl_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = sram_arb_ctrl_pkg::ADDR_WIDTH,
    parameter int INIT_ENABLE = 1
) (
    input  logic                    clk0,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    init_done,
    output logic                    csb0,
    output logic                    web0,
    output logic                    wmask0,
    output logic [ADDR_WIDTH-1:0]   addr0,
    output logic [DATA_WIDTH-1:0]   din0,
    input  logic [DATA_WIDTH-1:0]   dout0
);
    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [1:0]              grant;
    logic                    rr_ptr;
    logic                    gsel, we_sel, rd_issue;
    logic [ADDR_WIDTH-1:0]   addr_sel;
    logic [DATA_WIDTH-1:0]   wdata_sel;
    logic [RD_LAT-1:0]       trk_vld, trk_port;

    sram_rr_arb2 u_arb (
        .clk0   (clk0),
        .rst_n  (rst_n),
        .enable (state == ST_RUN),
        .valid  (req_valid),
        .grant  (grant),
        .rr_ptr (rr_ptr)
    );

    assign req_ready = grant;
    assign init_done = (state == ST_RUN);
    assign wmask0    = 1'b1;

    // next state and granted-request mux
    always_comb begin
        state_nx  = (state == ST_INIT && &init_cnt) ? ST_RUN : state;
        gsel      = grant[1];
        we_sel    = gsel ? req_we[1] : req_we[0];
        addr_sel  = gsel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        wdata_sel = gsel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        rd_issue  = |grant && !we_sel;
    end

    // state register and zero-fill address counter
    always_ff @(posedge clk0 or negedge rst_n)
        if (!rst_n) begin
            state    <= (INIT_ENABLE != 0) ? ST_INIT : ST_RUN;
            init_cnt <= '0;
        end else begin
            state    <= state_nx;
            init_cnt <= (state == ST_INIT) ? init_cnt + 1'b1 : init_cnt;
        end

    // macro pin registers: zero writes during fill, granted request during run
    always_ff @(posedge clk0 or negedge rst_n)
        if (!rst_n) begin
            csb0  <= 1'b1;
            web0  <= 1'b1;
            addr0 <= '0;
            din0  <= '0;
        end else if (state == ST_INIT) begin
            csb0  <= 1'b0;
            web0  <= 1'b0;
            addr0 <= init_cnt;
            din0  <= '0;
        end else if (|grant) begin
            csb0  <= 1'b0;
            web0  <= !we_sel;
            addr0 <= addr_sel;
            din0  <= wdata_sel;
        end else
            csb0  <= 1'b1;

    // read tracking shift; the last stage steers dout0 back to its port
    always_ff @(posedge clk0 or negedge rst_n)
        if (!rst_n) begin
            trk_vld   <= '0;
            trk_port  <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            trk_vld   <= {trk_vld[RD_LAT-2:0], rd_issue};
            trk_port  <= {trk_port[RD_LAT-2:0], gsel};
            rsp_valid <= {trk_vld[RD_LAT-1] & trk_port[RD_LAT-1], trk_vld[RD_LAT-1] & ~trk_port[RD_LAT-1]};
            rsp_rdata <= trk_vld[RD_LAT-1] ? dout0 : rsp_rdata;
        end
endmodule
